// File: rtl/byte_decode.sv
`default_nettype none
// ============================================================================
// Module      : byte_decode
// Description : Unpacks 256 D-bit coefficients from an LSB-first byte array,
//               reducing mod Q when D=12; one registered stage.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_decode #(
    parameter int D = 12,
    parameter int Q = 3329
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    input  logic [32*D-1:0][7:0]   b_i,
    output logic                   valid_o,
    output logic [255:0][D-1:0]    f_o
);

    if (D < 1 || D > 12) begin : g_bad_d
        $error("byte_decode: D=%0d outside legal range 1..12", D);
    end

    // Byte 0 sits in the low bits, so the packed array is already the LSB-first stream.
    logic [256*D-1:0]        w_stream;
    logic [255:0][D-1:0]     w_dec;
    logic [255:0][D-1:0]     f_d;
    logic [255:0][D-1:0]     f_q;
    logic                    valid_q;

    assign w_stream = b_i;

    for (genvar gi = 0; gi < 256; gi++) begin : g_coef
        logic [D-1:0] w_raw;
        assign w_raw = w_stream[gi*D +: D];
        if (D == 12) begin : g_mod
            assign w_dec[gi] = (w_raw >= D'(Q)) ? (w_raw - D'(Q)) : w_raw;
        end else begin : g_plain
            assign w_dec[gi] = w_raw;
        end
    end

    always_comb begin
        f_d = f_q;
        if (valid_i) begin
            f_d = w_dec;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            f_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            f_q     <= f_d;
            valid_q <= valid_i;
        end
    end

    assign f_o     = f_q;
    assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_decode
// Description : Directed and random checks of byte_decode at D=1, 8 and 12.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_decode;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  valid_i;
    logic [31:0][7:0]      b1;
    logic [255:0][7:0]     b8;
    logic [383:0][7:0]     b12;
    logic                  vo1, vo8, vo12;
    logic [255:0][0:0]     f1;
    logic [255:0][7:0]     f8;
    logic [255:0][11:0]    f12;

    byte_decode #(.D(1))  u_d1  (.clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
                                 .b_i(b1),  .valid_o(vo1),  .f_o(f1));
    byte_decode #(.D(8))  u_d8  (.clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
                                 .b_i(b8),  .valid_o(vo8),  .f_o(f8));
    byte_decode #(.D(12)) u_d12 (.clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
                                 .b_i(b12), .valid_o(vo12), .f_o(f12));

    always #5 clk_i = ~clk_i;

    logic [7:0] by [384];
    int         e1 [256];
    int         e8 [256];
    int         e12[256];
    logic       ev;
    int         total = 0;
    int         bad   = 0;

    // Reference: walk the byte array bit by bit as an LSB-first stream.
    function automatic int coef(int dd, int i);
        int raw = 0;
        for (int j = 0; j < dd; j++) begin
            int k = i*dd + j;
            logic [7:0] bt = by[k/8];
            if (bt[k%8]) raw += (1 << j);
        end
        if (dd == 12 && raw >= 3329) raw -= 3329;
        return raw;
    endfunction

    task automatic pack12(input int c[256]);
        for (int k = 0; k < 384; k++) by[k] = 8'h00;
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 12; j++) begin
                int k = i*12 + j;
                logic [7:0] bt = by[k/8];
                bt[k%8] = c[i][j];
                by[k/8] = bt;
            end
    endtask

    task automatic apply(input logic v);
        for (int k = 0; k < 32;  k++) b1[k]  = by[k];
        for (int k = 0; k < 256; k++) b8[k]  = by[k];
        for (int k = 0; k < 384; k++) b12[k] = by[k];
        valid_i = v;
    endtask

    task automatic fill(input logic [7:0] val);
        for (int k = 0; k < 384; k++) by[k] = val;
    endtask

    task automatic clear_model();
        ev = 1'b0;
        for (int i = 0; i < 256; i++) begin e1[i] = 0; e8[i] = 0; e12[i] = 0; end
    endtask

    // Advance one edge and update the model from what was presented at that edge.
    task automatic step();
        @(posedge clk_i);
        #1;
        ev = valid_i;
        if (valid_i) begin
            for (int i = 0; i < 256; i++) begin
                e1[i] = coef(1, i); e8[i] = coef(8, i); e12[i] = coef(12, i);
            end
        end
    endtask

    task automatic check(input string tag);
        total++;
        assert ({vo1, vo8, vo12} === {3{ev}}) else begin
            bad++;
            $error("FAIL %s valid_o got=%b%b%b exp=%b", tag, vo1, vo8, vo12, ev);
        end
        for (int i = 0; i < 256; i++) begin
            total++;
            assert ({11'b0, f1[i]} === 12'(e1[i])) else begin
                bad++;
                $error("FAIL %s d1.f[%0d] got=%0d exp=%0d", tag, i, f1[i], e1[i]);
            end
            total++;
            assert ({4'b0, f8[i]} === 12'(e8[i])) else begin
                bad++;
                $error("FAIL %s d8.f[%0d] got=%0d exp=%0d", tag, i, f8[i], e8[i]);
            end
            total++;
            assert (f12[i] === 12'(e12[i])) else begin
                bad++;
                $error("FAIL %s d12.f[%0d] got=%0d exp=%0d", tag, i, f12[i], e12[i]);
            end
        end
    endtask

    initial begin
        int c[256];
        fill(8'h00);
        apply(1'b0);
        rst_i = 1'b1;
        clear_model();
        #1;
        check("reset_async");
        @(negedge clk_i);
        rst_i = 1'b0;
        step(); check("reset_release_idle");

        // D=1 alternating bits; D=8/12 see the same 0xAA bytes.
        fill(8'hAA); apply(1'b1);
        step(); check("aa_pattern");
        for (int i = 0; i < 256; i++) begin
            total++;
            assert ({11'b0, f1[i]} === 12'(i % 2)) else begin
                bad++;
                $error("FAIL d1_literal f[%0d] got=%0d exp=%0d", i, f1[i], i % 2);
            end
        end
        apply(1'b0);
        step(); check("aa_hold");

        for (int k = 0; k < 384; k++) by[k] = 8'(k);
        apply(1'b1);
        step(); check("ramp_bytes");

        for (int i = 0; i < 256; i++) c[i] = i;
        pack12(c); apply(1'b1);
        step(); check("d12_in_range");

        fill(8'hFF); apply(1'b1);
        step(); check("all_ff");
        total++;
        assert (f12[17] === 12'd766) else begin
            bad++;
            $error("FAIL d12_ff_literal got=%0d exp=766", f12[17]);
        end

        for (int i = 0; i < 256; i++) c[i] = (i % 2 == 0) ? 3329 : 3328;
        pack12(c); apply(1'b1);
        step(); check("d12_boundary");

        // Back-to-back inputs, no bubble.
        fill(8'h01); apply(1'b1); step(); check("b2b_1");
        fill(8'h02); apply(1'b1); step(); check("b2b_2");
        fill(8'h03); apply(1'b1); step(); check("b2b_3");
        total++;
        assert (f8[200] === 8'd3) else begin
            bad++;
            $error("FAIL b2b_literal got=%0d exp=3", f8[200]);
        end
        apply(1'b0); step(); check("b2b_idle");

        // Reset between accepting edge and the output cycle.
        fill(8'h5C); apply(1'b1);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1 clear_model();
        check("mid_reset_async");
        apply(1'b0);
        step(); clear_model(); check("mid_reset_held");
        @(negedge clk_i);
        rst_i = 1'b0;
        fill(8'h37); apply(1'b1);
        step(); check("after_reset");

        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < 384; k++) by[k] = 8'($urandom);
            apply(1'($urandom));
            step(); check("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/byte_decode.md
BYTE_DECODE -- requirements
Module: byte_decode

Interface
REQ-001 The block SHALL have parameter D, default 12, giving the bits per decoded coefficient; legal range is 1..12.
REQ-002 The block SHALL have parameter Q, default 3329, giving the modulus applied when D=12.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 The block SHALL have port clk_i, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port valid_i, input, 1 bit: b_i holds a byte array to decode this cycle.
REQ-007 The block SHALL have port b_i, input, packed [32*D-1:0][7:0]: byte array, with byte 0 at index 0.
REQ-008 The block SHALL have port valid_o, output, 1 bit: f_o holds a newly decoded result.
REQ-009 The block SHALL have port f_o, output, packed [255:0][D-1:0]: 256 decoded coefficients, with coefficient 0 at index 0.

Function
REQ-010 The bit stream SHALL be formed LSB-first: stream bit k = bit (k mod 8) of byte b_i[k/8], for k = 0..256*D-1.
REQ-011 Raw coefficient i SHALL equal the sum over j=0..D-1 of stream bit (i*D+j) times 2^j.
REQ-012 For D<12, the decoded coefficient i SHALL equal the raw coefficient i (implicitly mod 2^D).
REQ-013 For D=12, the decoded coefficient i SHALL equal raw mod Q, computed as one conditional subtraction: if raw >= 3329 then raw-3329, else raw.
REQ-014 The decode and reduction SHALL be combinational from b_i; f_o SHALL be registered.
REQ-015 Latency SHALL be 1 cycle: when valid_i=1 at rising edge N, f_o holds the decode of that b_i and valid_o=1 after edge N.
REQ-016 There SHALL be no back-pressure; the block SHALL accept a new input every cycle at full throughput.
REQ-017 When valid_i=0 at an edge, valid_o SHALL be 0 after that edge and f_o SHALL hold its previous value.
REQ-018 Back-to-back valid_i cycles SHALL each produce their own result one cycle later, with no bubble and no loss.
REQ-019 A D value outside 1..12 SHALL cause an elaboration-time error.
REQ-020 The block SHALL have no internal state other than the f_o and valid_o registers.

Reset
REQ-021 While rst_i=1, valid_o SHALL be 0 and every f_o coefficient SHALL be 0, immediately and independent of clk_i.
REQ-022 Reset asserted in the middle of a stream SHALL discard any in-flight result; the first valid_i after reset release SHALL yield a normal 1-cycle-latency result.

Verification
REQ-023 Reset: assert rst_i with no clock edge -> valid_o=0 and f_o all zeros at once; release rst_i with valid_i=0 -> outputs stay 0.
REQ-024 D=1: pack f[i]=i%2 (bytes 0x..AA pattern, i.e. every byte 0xAA) with valid_i=1 for one cycle -> one cycle later valid_o=1 and f_o[i]=i%2 for all 256 entries; the next cycle valid_o=0 and f_o is held.
REQ-025 D=8: b_i[i]=i for i=0..255 -> f_o[i]=i one cycle later.
REQ-026 D=12, in-range: pack f[i]=i%3329 (i.e. i), 12 bits LSB-first -> f_o[i]=i; out-of-range: all bytes 0xFF -> every f_o[i]=766 (4095-3329); raw 3329 -> 0; raw 3328 -> 3328.
REQ-027 Throughput: D=8, three consecutive valid_i cycles with b_i all 0x01, then 0x02, then 0x03 -> valid_o high for three consecutive cycles with f_o all 1, 2, 3 in order.
REQ-028 Mid-operation reset: D=8, assert rst_i asynchronously between an accepting edge and the output cycle -> valid_o=0 and f_o=0 immediately; after release, a new input decodes correctly.
